// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer capture controller.
// Packet layout (29 bits after address strip): {status, num_bytes, 2'b00, code, data}.
package la_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } la_state_e;

    localparam logic [3:0] LA_REG_DIV_LO       = 4'h0;
    localparam logic [3:0] LA_REG_DIV_HI       = 4'h1;
    localparam logic [3:0] LA_REG_TRIG_MASK    = 4'h2;
    localparam logic [3:0] LA_REG_TRIG_VAL     = 4'h3;
    localparam logic [3:0] LA_REG_SAMPLE_COUNT = 4'h4;
    localparam logic [3:0] LA_REG_CONTROL      = 4'h5;

    localparam logic [7:0] LA_ST_DONE    = 8'h01;
    localparam logic [7:0] LA_ST_STOPPED = 8'h02;

    localparam int LA_CFG_FLAG_BIT = 28;
    localparam int LA_REG_ID_MSB   = 23;
    localparam int LA_REG_ID_LSB   = 20;
    localparam int LA_DIV_WIDTH    = 24;

    localparam logic [1:0] LA_NUM_BYTES = 2'b10;

    function automatic logic [28:0] la_make_packet(input logic       is_status,
                                                   input logic [7:0]  code,
                                                   input logic [15:0] data);
        return {is_status, LA_NUM_BYTES, 2'b00, code, data};
    endfunction

endpackage

// File: rtl/la_sample_timer.sv
// Sample-rate divider: counts 0..div and ticks on the terminal count,
// giving one tick every div+1 cycles while enabled.
module la_sample_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [23:0] div,
    output logic        tick
);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;

    assign tick = en && (cnt_q == div);

    // Next count: clear wins, otherwise wrap at div while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 24'd0;
        end else if (en) begin
            cnt_d = (cnt_q == div) ? 24'd0 : cnt_q + 24'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture controller for the 16-pin GPIO logic analyzer: config decode,
// trigger qualification, sample capture and a one-entry output slot.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int WIDTH             = 32,
    parameter int PERIPH_ADDR_WIDTH = 3,
    parameter int PIN_WIDTH         = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WIDTH-1:0]                   cfg_packet,
    input  logic                               cfg_valid,
    input  logic [PIN_WIDTH-1:0]               pin_vals,
    output logic [WIDTH-PERIPH_ADDR_WIDTH-1:0] out_packet,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
    output logic                               overrun
);

    localparam int OUT_W = WIDTH - PERIPH_ADDR_WIDTH;

    logic [PIN_WIDTH-1:0]    sync1_q, sync2_q;
    la_state_e               state_q, state_d;
    logic [LA_DIV_WIDTH-1:0] div_q, div_d;
    logic [PIN_WIDTH-1:0]    trig_mask_q, trig_mask_d;
    logic [PIN_WIDTH-1:0]    trig_val_q, trig_val_d;
    logic [15:0]             sample_count_q, sample_count_d;
    logic [15:0]             captured_q, captured_d;
    logic [7:0]              code_q, code_d;
    logic [OUT_W-1:0]        out_packet_q, out_packet_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    busy_q, busy_d;

    logic        cfg_hit_s, cfg_wr_s, arm_s, stop_s;
    logic [3:0]  reg_id_s;
    logic [15:0] value_s;
    logic        tick_s, tmr_clr_s, tmr_en_s, trig_hit_s, slot_free_s;
    logic        capture_s, load_status_s, clr_overrun_s;
    logic [15:0] cap_inc_s;
    logic        unused_cfg_bits_s;

    assign cfg_hit_s = cfg_valid && cfg_packet[LA_CFG_FLAG_BIT];
    assign reg_id_s  = cfg_packet[LA_REG_ID_MSB:LA_REG_ID_LSB];
    assign value_s   = cfg_packet[15:0];
    assign cfg_wr_s  = cfg_hit_s && (state_q == ST_IDLE);
    // Stop takes priority over arm when both control bits are set.
    assign arm_s  = cfg_hit_s && (reg_id_s == LA_REG_CONTROL) && value_s[0] && !value_s[1];
    assign stop_s = cfg_hit_s && (reg_id_s == LA_REG_CONTROL) && value_s[1];
    assign unused_cfg_bits_s = ^{cfg_packet[WIDTH-1:LA_CFG_FLAG_BIT+1], cfg_packet[27:24],
                                 cfg_packet[19:16]};

    assign tmr_clr_s   = (state_q == ST_IDLE) && arm_s;
    assign tmr_en_s    = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign trig_hit_s  = ((sync2_q ^ trig_val_q) & trig_mask_q) == {PIN_WIDTH{1'b0}};
    assign slot_free_s = !out_valid_q || out_ready;
    assign cap_inc_s   = (captured_q == 16'hFFFF) ? captured_q : captured_q + 16'd1;

    la_sample_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr_s),
        .en   (tmr_en_s),
        .div  (div_q),
        .tick (tick_s)
    );

    // Configuration registers are writable only while idle.
    always_comb begin
        div_d          = div_q;
        trig_mask_d    = trig_mask_q;
        trig_val_d     = trig_val_q;
        sample_count_d = sample_count_q;
        if (cfg_wr_s) begin
            case (reg_id_s)
                LA_REG_DIV_LO:       div_d[15:0]    = value_s;
                LA_REG_DIV_HI:       div_d[23:16]   = value_s[7:0];
                LA_REG_TRIG_MASK:    trig_mask_d    = value_s[PIN_WIDTH-1:0];
                LA_REG_TRIG_VAL:     trig_val_d     = value_s[PIN_WIDTH-1:0];
                LA_REG_SAMPLE_COUNT: sample_count_d = value_s;
                default:             div_d          = div_q;
            endcase
        end else begin
            div_d = div_q;
        end
    end

    // Capture FSM: next state, sample bookkeeping and completion code.
    always_comb begin
        state_d       = state_q;
        captured_d    = captured_q;
        code_d        = code_q;
        capture_s     = 1'b0;
        load_status_s = 1'b0;
        clr_overrun_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_s) begin
                    state_d       = ST_ARMED;
                    captured_d    = 16'd0;
                    clr_overrun_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (stop_s) begin
                    state_d = ST_DONE;
                    code_d  = LA_ST_STOPPED;
                end else if (tick_s && trig_hit_s) begin
                    capture_s  = 1'b1;
                    captured_d = 16'd1;
                    if (sample_count_q == 16'd1) begin
                        state_d = ST_DONE;
                        code_d  = LA_ST_DONE;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (stop_s) begin
                    state_d = ST_DONE;
                    code_d  = LA_ST_STOPPED;
                end else if (tick_s) begin
                    capture_s  = 1'b1;
                    captured_d = cap_inc_s;
                    if ((sample_count_q != 16'd0) && (cap_inc_s == sample_count_q)) begin
                        state_d = ST_DONE;
                        code_d  = LA_ST_DONE;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                if (slot_free_s) begin
                    load_status_s = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output slot: status is never dropped; a sample hitting a busy slot sets overrun.
    always_comb begin
        out_valid_d  = out_valid_q && !out_ready;
        out_packet_d = out_packet_q;
        overrun_d    = overrun_q;
        if (load_status_s) begin
            out_valid_d  = 1'b1;
            out_packet_d = la_make_packet(1'b1, code_q, captured_q);
        end else if (capture_s) begin
            if (slot_free_s) begin
                out_valid_d  = 1'b1;
                out_packet_d = la_make_packet(1'b0, 8'h00, sync2_q[15:0]);
            end else begin
                overrun_d = 1'b1;
            end
        end else if (clr_overrun_s) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, configuration, synchronizer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q        <= {PIN_WIDTH{1'b0}};
            sync2_q        <= {PIN_WIDTH{1'b0}};
            state_q        <= ST_IDLE;
            div_q          <= {LA_DIV_WIDTH{1'b0}};
            trig_mask_q    <= {PIN_WIDTH{1'b0}};
            trig_val_q     <= {PIN_WIDTH{1'b0}};
            sample_count_q <= 16'd0;
            captured_q     <= 16'd0;
            code_q         <= 8'h00;
            out_packet_q   <= {OUT_W{1'b0}};
            out_valid_q    <= 1'b0;
            overrun_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            sync1_q        <= pin_vals;
            sync2_q        <= sync1_q;
            state_q        <= state_d;
            div_q          <= div_d;
            trig_mask_q    <= trig_mask_d;
            trig_val_q     <= trig_val_d;
            sample_count_q <= sample_count_d;
            captured_q     <= captured_d;
            code_q         <= code_d;
            out_packet_q   <= out_packet_d;
            out_valid_q    <= out_valid_d;
            overrun_q      <= overrun_d;
            busy_q         <= busy_d;
        end
    end

    assign out_packet = out_packet_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Self-checking bench for la_capture_ctrl: a cycle-indexed reference model
// predicts every accepted packet (value and cycle) from the capture rules.
module tb_la_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_packet;
    logic        cfg_valid;
    logic [15:0] pin_vals;
    logic [28:0] out_packet;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    la_capture_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_packet (cfg_packet),
        .cfg_valid  (cfg_valid),
        .pin_vals   (pin_vals),
        .out_packet (out_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    int errors = 0;
    int checks = 0;
    int n      = 0;

    logic [15:0] cur_pins;
    logic        cur_rdy;

    logic [28:0] got_q[$];
    logic [28:0] exp_q[$];
    int          got_c[$];
    int          exp_c[$];

    localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DONE = 3;
    int          m_st;
    int          m_arm;
    logic [23:0] m_div;
    logic [15:0] m_mask, m_tv, m_cnt, m_cap, ph1, ph2;
    logic [7:0]  m_code;
    logic        m_full, m_ovr;
    logic [28:0] m_pkt;

    function automatic logic [28:0] pk(input logic st, input logic [7:0] code, input logic [15:0] d);
        return {st, 2'b10, 2'b00, code, d};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_arm = 0; m_div = 24'd0; m_mask = 16'd0; m_tv = 16'd0;
        m_cnt = 16'd0; m_cap = 16'd0; m_code = 8'd0; m_full = 1'b0; m_ovr = 1'b0;
        m_pkt = 29'd0; ph1 = 16'd0; ph2 = 16'd0;
    endtask

    // One clock edge of the reference behaviour; ph2 is the pin value seen two edges late.
    task automatic model_edge(input logic [31:0] pkt, input logic pv, input logic [15:0] pins,
                              input logic rdy);
        logic cfg, arm, stop, tick, hit, free, cap;
        logic [3:0]  id;
        logic [15:0] v;
        cfg  = pv && pkt[28];
        id   = pkt[23:20];
        v    = pkt[15:0];
        arm  = cfg && (id == 4'h5) && v[0] && !v[1];
        stop = cfg && (id == 4'h5) && v[1];
        tick = (m_st == M_ARMED || m_st == M_CAP) &&
               (((n - m_arm - 1) % (int'(m_div) + 1)) == int'(m_div));
        hit  = ((ph2 ^ m_tv) & m_mask) == 16'h0000;
        free = !m_full || rdy;
        cap  = 1'b0;
        if (m_full && rdy) begin
            exp_q.push_back(m_pkt);
            exp_c.push_back(n);
            m_full = 1'b0;
        end
        case (m_st)
            M_IDLE: begin
                if (cfg) begin
                    case (id)
                        4'h0: m_div[15:0]  = v;
                        4'h1: m_div[23:16] = v[7:0];
                        4'h2: m_mask       = v;
                        4'h3: m_tv         = v;
                        4'h4: m_cnt        = v;
                        default: ;
                    endcase
                end
                if (arm) begin
                    m_st = M_ARMED; m_arm = n; m_ovr = 1'b0; m_cap = 16'd0;
                end
            end
            M_ARMED: begin
                if (stop) begin
                    m_st = M_DONE; m_code = 8'h02;
                end else if (tick && hit) begin
                    cap = 1'b1; m_cap = 16'd1;
                    if (m_cnt == 16'd1) begin m_st = M_DONE; m_code = 8'h01; end
                    else m_st = M_CAP;
                end
            end
            M_CAP: begin
                if (stop) begin
                    m_st = M_DONE; m_code = 8'h02;
                end else if (tick) begin
                    cap = 1'b1;
                    if (m_cap != 16'hFFFF) m_cap = m_cap + 16'd1;
                    if (m_cnt != 16'd0 && m_cap == m_cnt) begin m_st = M_DONE; m_code = 8'h01; end
                end
            end
            M_DONE: begin
                if (free) begin
                    m_full = 1'b1; m_pkt = pk(1'b1, m_code, m_cap); m_st = M_IDLE;
                end
            end
            default: ;
        endcase
        if (cap) begin
            if (free) begin m_full = 1'b1; m_pkt = pk(1'b0, 8'h00, ph2); end
            else m_ovr = 1'b1;
        end
        ph2 = ph1;
        ph1 = pins;
        n   = n + 1;
    endtask

    task automatic step(input logic [31:0] pkt, input logic pv);
        @(negedge clk);
        cfg_packet = pkt; cfg_valid = pv; pin_vals = cur_pins; out_ready = cur_rdy;
        if (out_valid && out_ready) begin
            got_q.push_back(out_packet);
            got_c.push_back(n);
        end
        @(posedge clk);
        model_edge(pkt, pv, cur_pins, cur_rdy);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(32'd0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] id, input logic [15:0] v);
        step({3'b101, 1'b1, 4'h0, id, 4'h0, v}, 1'b1);
    endtask

    task automatic setup(input logic [23:0] div, input logic [15:0] mask, input logic [15:0] tv,
                         input logic [15:0] cnt);
        wr(4'h0, div[15:0]); wr(4'h1, {8'h00, div[23:16]});
        wr(4'h2, mask); wr(4'h3, tv); wr(4'h4, cnt);
    endtask

    task automatic drain();
        cur_rdy = 1'b1;
        for (int i = 0; i < 400 && !(m_st == M_IDLE && !m_full); i++) step(32'd0, 1'b0);
        idle(1);
    endtask

    task automatic clear_q();
        got_q.delete(); exp_q.delete(); got_c.delete(); exp_c.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_packet = 32'd0; cfg_valid = 1'b0; pin_vals = 16'd0; out_ready = 1'b0;
        cur_pins = 16'd0; cur_rdy = 1'b1;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_packet !== 29'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b p=%h b=%b o=%b exp all zero",
                     out_valid, out_packet, busy, overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        clear_q();
        cur_pins = 16'h1234; cur_rdy = 1'b1;
        setup(24'd3, 16'h0000, 16'h0000, 16'd4);
        wr(4'h5, 16'h0001);
        drain();
        checks++;
        if (got_q.size() != 5 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=5 model=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_c[i] != exp_c[i]) begin
                errors++;
                $display("FAIL basic_pkt%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_c[i], exp_q[i], exp_c[i]);
            end
        end
        if (got_q.size() == 5) begin
            checks++;
            if (got_q[0] !== 29'h08001234 || got_q[4] !== 29'h18010004 || got_c[1] - got_c[0] != 4) begin
                errors++;
                $display("FAIL basic_fixed got first=%h last=%h gap=%0d exp 08001234 18010004 4",
                         got_q[0], got_q[4], got_c[1] - got_c[0]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", busy); end
    endtask

    task automatic test_trigger();
        clear_q();
        cur_pins = 16'h0000;
        setup(24'd0, 16'h0001, 16'h0001, 16'd2);
        wr(4'h5, 16'h0001);
        idle(10);
        checks++;
        if (got_q.size() != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL trig_wait got pkts=%0d busy=%b exp 0 1", got_q.size(), busy);
        end
        cur_pins = 16'h0001;
        drain();
        checks++;
        if (got_q.size() != 3 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL trig_count got=%0d exp=3 model=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_c[i] != exp_c[i]) begin
                errors++;
                $display("FAIL trig_pkt%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_c[i], exp_q[i], exp_c[i]);
            end
        end
        if (got_q.size() == 3) begin
            checks++;
            if (got_q[0] !== 29'h08000001 || got_q[2] !== 29'h18010002) begin
                errors++;
                $display("FAIL trig_fixed got first=%h last=%h exp 08000001 18010002", got_q[0], got_q[2]);
            end
        end
    endtask

    task automatic test_stop();
        clear_q();
        setup(24'd1, 16'h0000, 16'h0000, 16'd0);
        wr(4'h5, 16'h0001);
        for (int i = 0; i < 200 && m_cap < 16'd5; i++) begin
            cur_pins = 16'($urandom);
            step(32'd0, 1'b0);
        end
        wr(4'h5, 16'h0002);
        drain();
        checks++;
        if (got_q.size() != 6 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stop_count got=%0d exp=6 model=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_c[i] != exp_c[i]) begin
                errors++;
                $display("FAIL stop_pkt%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_c[i], exp_q[i], exp_c[i]);
            end
        end
        if (got_q.size() == 6) begin
            checks++;
            if (got_q[5] !== 29'h18020005) begin
                errors++;
                $display("FAIL stop_status got=%h exp=18020005", got_q[5]);
            end
        end
    endtask

    task automatic test_overrun();
        clear_q();
        cur_pins = 16'hBEEF; cur_rdy = 1'b0;
        setup(24'd0, 16'h0000, 16'h0000, 16'd8);
        wr(4'h5, 16'h0001);
        idle(14);
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1 || out_packet !== 29'h0800BEEF || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovr_hold got o=%b v=%b p=%h b=%b exp 1 1 0800beef 1",
                     overrun, out_valid, out_packet, busy);
        end
        drain();
        checks++;
        if (got_q.size() != 2 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ovr_count got=%0d exp=2 model=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_c[i] != exp_c[i]) begin
                errors++;
                $display("FAIL ovr_pkt%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_c[i], exp_q[i], exp_c[i]);
            end
        end
        if (got_q.size() == 2) begin
            checks++;
            if (got_q[1] !== 29'h18010008 || overrun !== 1'b1) begin
                errors++;
                $display("FAIL ovr_status got=%h o=%b exp=18010008 1", got_q[1], overrun);
            end
        end
    endtask

    task automatic test_ignore();
        clear_q();
        cur_pins = 16'h00A5; cur_rdy = 1'b1;
        setup(24'd1, 16'h0000, 16'h0000, 16'd6);
        wr(4'h5, 16'h0001);
        idle(4);
        wr(4'h0, 16'h0007);
        drain();
        checks++;
        if (got_q.size() != 7 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ign_count got=%0d exp=7 model=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_c[i] != exp_c[i]) begin
                errors++;
                $display("FAIL ign_pkt%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_c[i], exp_q[i], exp_c[i]);
            end
        end
        for (int i = 1; i < got_c.size() && i < 6; i++) begin
            checks++;
            if (got_c[i] - got_c[i-1] != 2) begin
                errors++;
                $display("FAIL ign_period%0d got=%0d exp=2", i, got_c[i] - got_c[i-1]);
            end
        end
        step({3'b000, 1'b0, 4'h0, 4'h5, 4'h0, 16'h0001}, 1'b1);
        idle(3);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ign_data_arm got b=%b v=%b exp 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        cur_rdy = 1'b0;
        setup(24'd0, 16'h0000, 16'h0000, 16'd0);
        wr(4'h5, 16'h0001);
        for (int i = 0; i < 6; i++) begin
            cur_pins = 16'($urandom);
            step(32'd0, 1'b0);
        end
        cur_pins = 16'h0000; pin_vals = 16'h0000; cfg_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got o=%b b=%b exp 1 1", overrun, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got v=%b b=%b o=%b exp 0 0 0", out_valid, busy, overrun);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_q();
        cur_pins = 16'h5A5A; cur_rdy = 1'b1;
        setup(24'd2, 16'h0000, 16'h0000, 16'd3);
        wr(4'h5, 16'h0001);
        drain();
        checks++;
        if (got_q.size() != 4 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rstmid_count got=%0d exp=4 model=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_c[i] != exp_c[i]) begin
                errors++;
                $display("FAIL rstmid_pkt%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_c[i], exp_q[i], exp_c[i]);
            end
        end
        if (got_q.size() == 4) begin
            checks++;
            if (got_q[3] !== 29'h18010003) begin
                errors++;
                $display("FAIL rstmid_status got=%h exp=18010003", got_q[3]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            clear_q();
            cur_rdy = 1'b1;
            setup(24'($urandom_range(0, 3)), 16'($urandom) & 16'h0003, 16'($urandom),
                  16'($urandom_range(0, 5)));
            wr(4'h5, 16'h0001);
            for (int c = 0; c < 30; c++) begin
                cur_pins = 16'($urandom);
                cur_rdy  = 1'($urandom_range(0, 1));
                step(32'd0, 1'b0);
                checks++;
                if (busy !== (m_st != M_IDLE) || out_valid !== m_full || overrun !== m_ovr ||
                    (m_full && out_packet !== m_pkt)) begin
                    errors++;
                    $display("FAIL rand%0d_cyc%0d got b=%b v=%b o=%b p=%h exp b=%b v=%b o=%b p=%h",
                             it, c, busy, out_valid, overrun, out_packet,
                             (m_st != M_IDLE), m_full, m_ovr, m_pkt);
                end
            end
            wr(4'h5, 16'h0002);
            drain();
            checks++;
            if (got_q.size() != exp_q.size() || overrun !== m_ovr) begin
                errors++;
                $display("FAIL rand%0d_count got=%0d o=%b exp=%0d o=%b", it, got_q.size(), overrun,
                         exp_q.size(), m_ovr);
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i] || got_c[i] != exp_c[i]) begin
                    errors++;
                    $display("FAIL rand%0d_pkt%0d got=%h@%0d exp=%h@%0d", it, i, got_q[i], got_c[i],
                             exp_q[i], exp_c[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trigger();
        test_stop();
        test_overrun();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
Capture controller for the 16-pin GPIO logic analyzer peripheral.
- Decodes host configuration packets: sample divider, trigger mask/value, sample count, arm/stop.
- Generates the sample tick, qualifies the trigger and counts captured samples.
- Emits data packets, then one terminating status packet, through a valid/ready handshake toward the peripheral's TX path.

Parameters:
WIDTH, 32, full packet width
PERIPH_ADDR_WIDTH, 3, address bits stripped from outgoing packets (bits 31-29)
PIN_WIDTH, 16, number of sampled pins

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
cfg_packet  input  WIDTH  host packet; [28]=config flag, [23:20]=reg id, [15:0]=value
cfg_valid  input  1  cfg_packet valid for one cycle; always accepted
pin_vals  input  PIN_WIDTH  asynchronous pin inputs
out_packet  output  WIDTH-PERIPH_ADDR_WIDTH  outgoing packet (bits 28-0 of packet format)
out_valid  output  1  out_packet holds a packet
out_ready  input  1  consumer accepts when out_valid&&out_ready
busy  output  1  state != IDLE
overrun  output  1  sticky; a sample was dropped since last arm

Behaviour:
- Reset: state IDLE, out_valid=0, out_packet=0, overrun=0, busy=0. Config registers reset as follows: div=0, mask=0, trig_val=0, sample_count=0. Sync flops=0.
- Pins pass through a 2-flop synchronizer; all trigger and capture logic uses the synced value (2-cycle latency).
- Config decode applies only when cfg_valid=1 and cfg_packet[28]=1; data packets ([28]=0) are ignored.
  - 0x0 DIV_LO: div[15:0]=value.
  - 0x1 DIV_HI: div[23:16]=value[7:0].
  - 0x2 TRIG_MASK.
  - 0x3 TRIG_VAL.
  - 0x4 SAMPLE_COUNT; 0 = continuous until stop.
  - 0x5 CONTROL: bit0 arm, bit1 stop; stop wins if both are set.
  - Other ids are ignored.
  - Writes to ids 0x0-0x4 are ignored unless state is IDLE.
- Sample tick: 24-bit counter cleared on arm; counts 0..div, tick when cnt==div, then wraps to 0. Period is div+1 cycles, so div=0 gives a tick every cycle. The counter runs only in ARMED/CAPTURE.
- FSM:
  - IDLE: arm → ARMED; clear overrun, sample counter and tick counter. Stop is ignored.
  - ARMED: on a tick where (synced & mask)==(trig_val & mask), that sample is captured as sample #1 → CAPTURE. mask=0 triggers on the first tick. Stop → DONE with code 0x02.
  - CAPTURE: capture on each tick. When captured==sample_count (sample_count≠0) → DONE with code 0x01, on the same cycle as the last capture. Stop → DONE with code 0x02; a tick on the same cycle as stop is not captured.
  - DONE: wait until the output slot is free (out_valid=0, or accepted this cycle). Then load the status packet {1'b1,2'b10,2'b00,code[7:0],captured[15:0]} → IDLE.
  - Arm while not IDLE is ignored.
- Data packet: {1'b0,2'b10,2'b00,8'h00,sample[15:0]}. It is registered and appears with out_valid one cycle after the tick.
- Output slot: one entry. out_valid clears on accept. An accept and a new load in the same cycle are legal (back-to-back).
  - Capture tick with the slot full and not accepted: the sample is dropped, still counted, and overrun←1.
  - The status packet is never dropped.
- Captured counter: 16 bits, saturates at 0xFFFF in continuous mode.
- Async reset mid-capture returns to IDLE immediately; any pending out_packet is discarded.

Decomposition:
- Package la_pkg:
  - state enum (IDLE, ARMED, CAPTURE, DONE);
  - reg-id constants LA_REG_DIV_LO..LA_REG_CONTROL;
  - status codes LA_ST_DONE=8'h01, LA_ST_STOPPED=8'h02;
  - packet field positions and the NUM_BYTES value 2'b10.
- Sub-module la_sample_timer: 24-bit divider counter with clear/enable inputs and a tick output.

Test Plan:
- div=3, count=4, mask=0, arm, pins=0x1234 → 4 data packets (data 0x1234) spaced 4 cycles, then status packet data 0x010004; busy falls.
- mask=0x0001, trig_val=0x0001, count=2, div=0; pins=0 for 10 cycles then 0x0001 → no packets before the edge; first packet data=0x0001, 2 data packets total, then status 0x010002.
- count=0, div=1, arm, stop after 5 ticks → 5 data packets, then status 0x020005.
- div=0, count=8, out_ready=0 → first packet held; 7 samples dropped; overrun=1; status 0x010008 is emitted after out_ready=1 and the held packet is accepted.
- DIV_LO write while CAPTURE → period unchanged; data packet with cfg_packet[28]=0 and id 0x5 → no arm.
- Assert rst mid-CAPTURE → out_valid=0, busy=0, overrun=0 immediately; re-arm runs normally.
